// File: rtl/dout_sequencer.sv
// dout_sequencer: replays a short table of {hold, pattern} steps into a
// digital output register, one strobe per step, under bus control.
//
// Register map (A): 0 CTRL/status, 1 STEP push / entry readback, 2 CLEAR,
// 3 reserved (reads zero, writes ignored).
//
// Build option: define DOUT_SEQ_LOOP_EN to enable loop mode (CTRL bit 2).
// Without it the loop bit is never stored and every sequence ends with done.
//
// Pause/step boundary: the cycle in which a pause is written is still a RUN
// cycle and consumes hold. If that cycle was the last cycle of a step, the
// sequencer advances to the next step and parks in PAUSE with that step's
// strobe pending. The strobe is then issued in the first RUN cycle after
// resume. If it was the last cycle of the final step (no loop), the sequence
// ends normally and the pause is dropped.
//
// DOUT_WE and done are masked by rst, so no strobe or done is visible while
// reset is asserted. This also covers a strobe that was registered just
// before reset.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no sequence active; table may be edited
// S_RUN   | stepping; hold_q counts down the cycles left in the step
// S_PAUSE | hold_q frozen; pend_q set if the current step is not yet strobed

module dout_sequencer #(
  parameter int N_OUTPUTS = 16,
  parameter int DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           A,
  input  logic [31:0]          WD,
  input  logic                 WE,
  output logic [31:0]          RD,
  output logic [N_OUTPUTS-1:0] DOUT_WD,
  output logic                 DOUT_WE,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef DOUT_SEQ_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          count_q;
  logic [IW-1:0]          idx_q;
  logic [15:0]            hold_q;
  logic                   loop_q;
  logic                   err_q;
  logic                   pend_q;
  logic [N_OUTPUTS-1:0]   dout_wd_q;
  logic                   dout_we_q;
  logic                   done_q;

  logic [N_OUTPUTS-1:0]   mem_pat_q  [DEPTH];
  logic [15:0]            mem_hold_q [DEPTH];

  logic                   wr_ctrl, wr_step, wr_clear;
  logic                   cmd_stop, cmd_start, cmd_pause, cmd_resume;
  logic                   step_ok;
  logic                   last_step_d;
  logic [IW-1:0]          next_idx_d;
  logic [15:0]            next_len_d;
  logic [15:0]            first_len_d;
  logic [15:0]            pat16;

  // A hold of zero still occupies one cycle.
  function automatic logic [15:0] step_len(input logic [15:0] h);
    return (h == 16'd0) ? 16'd1 : h;
  endfunction

  // Bus decode; only the highest-priority CTRL command in a write is acted on.
  always_comb begin
    wr_ctrl     = WE && (A == 2'd0);
    wr_step     = WE && (A == 2'd1);
    wr_clear    = WE && (A == 2'd2);
    cmd_stop    = wr_ctrl && WD[1];
    cmd_start   = wr_ctrl && !WD[1] && WD[0];
    cmd_pause   = wr_ctrl && !WD[1] && !WD[0] && WD[3];
    cmd_resume  = wr_ctrl && !WD[1] && !WD[0] && !WD[3] && WD[4];
    step_ok     = (state_q == S_IDLE) && (count_q != DEPTH_C);
    last_step_d = (({1'b0, idx_q} + CW'(1)) == count_q);
    next_idx_d  = last_step_d ? '0 : idx_q + IW'(1);
    next_len_d  = step_len(mem_hold_q[next_idx_d]);
    first_len_d = step_len(mem_hold_q[0]);
  end

  // Step table storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_step && step_ok) begin
      mem_pat_q[count_q[IW-1:0]]  <= WD[N_OUTPUTS-1:0];
      mem_hold_q[count_q[IW-1:0]] <= WD[31:16];
    end
  end

  // Sequencer FSM, table bookkeeping and registered output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      loop_q    <= 1'b0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      dout_wd_q <= '0;
      dout_we_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      dout_we_q <= 1'b0;
      done_q    <= 1'b0;

      if (wr_ctrl) loop_q <= LOOP_EN & WD[2];

      if (wr_step) begin
        if (step_ok) count_q <= count_q + CW'(1);
        else         err_q   <= 1'b1;
      end

      if (wr_clear && (state_q == S_IDLE)) begin
        count_q <= '0;
        err_q   <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_start && (count_q != '0)) begin
            state_q   <= S_RUN;
            idx_q     <= '0;
            hold_q    <= first_len_d;
            dout_we_q <= 1'b1;
            dout_wd_q <= mem_pat_q[0];
          end
        end
        S_RUN: begin
          if (cmd_stop) begin
            state_q <= S_IDLE;
          end else if (hold_q == 16'd1) begin
            if (last_step_d && !loop_q) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= next_idx_d;
              hold_q <= next_len_d;
              if (cmd_pause) begin
                state_q <= S_PAUSE;
                pend_q  <= 1'b1;
              end else begin
                dout_we_q <= 1'b1;
                dout_wd_q <= mem_pat_q[next_idx_d];
              end
            end
          end else begin
            hold_q <= hold_q - 16'd1;
            if (cmd_pause) state_q <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (cmd_stop) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
          end else if (cmd_resume) begin
            state_q <= S_RUN;
            if (pend_q) begin
              dout_we_q <= 1'b1;
              dout_wd_q <= mem_pat_q[idx_q];
              pend_q    <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Readback mux.
  always_comb begin
    RD    = '0;
    pat16 = '0;
    case (A)
      2'd0: begin
        RD[31]    = err_q;
        RD[23:16] = 8'(count_q);
        RD[15:8]  = 8'(idx_q);
        RD[4]     = loop_q;
        RD[1:0]   = state_q;
      end
      2'd1: begin
        pat16[N_OUTPUTS-1:0] = mem_pat_q[idx_q];
        RD = {mem_hold_q[idx_q], pat16};
      end
      default: RD = '0;
    endcase
  end

  assign DOUT_WD = dout_wd_q;
  assign DOUT_WE = dout_we_q & ~rst;
  assign done    = done_q & ~rst;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_dout_sequencer.sv
// Bench for dout_sequencer: directed scenarios followed by random bus traffic.
// All cycles are checked against a step-table reference model kept here.
// Follows DOUT_SEQ_LOOP_EN in the same way as the design.
module tb_dout_sequencer;
  localparam int N_OUTPUTS = 16;
  localparam int DEPTH     = 8;
`ifdef DOUT_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic [15:0] DOUT_WD;
  logic        DOUT_WE;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  dout_sequencer #(.N_OUTPUTS(N_OUTPUTS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .A(A), .WD(WD), .WE(WE), .RD(RD),
    .DOUT_WD(DOUT_WD), .DOUT_WE(DOUT_WE), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: a step table, plus a count of RUN cycles already spent in
  // the current step. A strobe is due in any RUN cycle that begins a step.
  bit          model_valid = 0;
  int          m_state;
  int          m_idx, m_elapsed, m_count;
  bit          m_loop, m_err, m_done;
  logic [15:0] m_pat  [DEPTH];
  int          m_hold [DEPTH];
  logic [15:0] m_wd;

  int          cyc = 0;
  int          strobe_cyc[$];
  logic [15:0] strobe_pat[$];
  int          done_cyc[$];
  logic [31:0] last_rd;
  logic [15:0] last_wd;
  logic        last_we, last_done, last_busy;

  task automatic model_edge(input logic r, input logic we, input logic [1:0] a, input logic [31:0] wd);
    int old_state, len;
    bit stop, start, pause, resume;
    if (r) begin
      m_state = 0; m_idx = 0; m_elapsed = 0; m_count = 0;
      m_loop = 0; m_err = 0; m_done = 0; m_wd = '0;
      model_valid = 1;
      return;
    end
    old_state = m_state;
    stop   = we && a == 2'd0 && wd[1];
    start  = we && a == 2'd0 && !wd[1] && wd[0];
    pause  = we && a == 2'd0 && !wd[1] && !wd[0] && wd[3];
    resume = we && a == 2'd0 && !wd[1] && !wd[0] && !wd[3] && wd[4];
    m_done = 0;
    case (old_state)
      0: if (start && m_count > 0) begin
           m_state = 1; m_idx = 0; m_elapsed = 0;
         end
      1: if (stop) m_state = 0;
         else begin
           m_elapsed++;
           len = (m_hold[m_idx] == 0) ? 1 : m_hold[m_idx];
           if (m_elapsed >= len) begin
             if (m_idx == m_count - 1 && !m_loop) begin
               m_state = 0; m_done = 1;
             end else begin
               m_idx = (m_idx + 1) % m_count; m_elapsed = 0;
             end
           end
           if (m_state == 1 && pause) m_state = 2;
         end
      default: if (stop) m_state = 0; else if (resume) m_state = 1;
    endcase
    if (we && a == 2'd0) m_loop = LOOP_EN && wd[2];
    if (we && a == 2'd1) begin
      if (m_count == DEPTH || old_state != 0) m_err = 1;
      else begin
        m_pat[m_count] = wd[15:0]; m_hold[m_count] = int'(wd[31:16]); m_count++;
      end
    end
    if (we && a == 2'd2 && old_state == 0) begin
      m_count = 0; m_err = 0;
    end
    if (m_state == 1 && m_elapsed == 0) m_wd = m_pat[m_idx];
  endtask

  task automatic compare();
    logic [31:0] exp_rd;
    last_rd = RD; last_wd = DOUT_WD; last_we = DOUT_WE; last_done = done; last_busy = busy;
    if (DOUT_WE === 1'b1) begin strobe_cyc.push_back(cyc); strobe_pat.push_back(DOUT_WD); end
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (!model_valid) return;
    check_val("dout_we", DOUT_WE, (!rst && m_state == 1 && m_elapsed == 0));
    check_val("dout_wd", DOUT_WD, m_wd);
    check_val("busy", busy, m_state != 0);
    check_val("done", done, (!rst && m_done));
    case (A)
      2'd0: begin
        exp_rd = {m_err, 7'b0, 8'(m_count), 8'(m_idx), 3'b0, m_loop, 2'b0, 2'(m_state)};
        check_val("rd_ctrl", RD, exp_rd);
      end
      2'd1: if (m_idx < m_count) check_val("rd_step", RD, {16'(m_hold[m_idx]), m_pat[m_idx]});
      default: check_val("rd_zero", RD, 32'h0);
    endcase
  endtask

  // One clock: apply inputs, check the current cycle, then advance the model.
  task automatic tick(input logic r, input logic we, input logic [1:0] a, input logic [31:0] wd);
    rst = r; WE = we; A = a; WD = wd;
    cyc++;
    #1;
    compare();
    @(posedge clk);
    model_edge(r, we, a, wd);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    tick(1'b0, 1'b1, a, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 2'($urandom_range(0, 3)), 32'h0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 2'd0, 32'h0);
    tick(1'b1, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic clear_log();
    strobe_cyc.delete(); strobe_pat.delete(); done_cyc.delete();
  endtask

  int          c_start, c_res, exp_n, exp_d, sel, k;
  logic [31:0] w;

  initial begin
    rst = 1'b1; WE = 1'b0; A = 2'd0; WD = 32'h0;
    @(negedge clk);
    do_reset();
    tick(1'b0, 1'b0, 2'd0, 32'h0);
    check_val("rst_rd_ctrl", last_rd, 32'h0);
    check_val("rst_dout_wd", last_wd, 16'h0);
    check_val("rst_busy", last_busy, 1'b0);

    // two steps, holds 3 and 1
    clear_log();
    wr(2'd1, {16'd3, 16'h00A5});
    wr(2'd1, {16'd1, 16'h5A00});
    wr(2'd0, 32'h1); c_start = cyc;
    idle(8);
    check_val("t1_n_strobes", strobe_cyc.size(), 2);
    if (strobe_cyc.size() == 2) begin
      check_val("t1_first_lat", strobe_cyc[0] - c_start, 1);
      check_val("t1_spacing", strobe_cyc[1] - strobe_cyc[0], 3);
      check_val("t1_pat0", strobe_pat[0], 16'h00A5);
      check_val("t1_pat1", strobe_pat[1], 16'h5A00);
    end
    check_val("t1_n_done", done_cyc.size(), 1);
    if (done_cyc.size() == 1 && strobe_cyc.size() == 2)
      check_val("t1_done_lat", done_cyc[0] - strobe_cyc[1], 1);
    check_val("t1_busy_after", busy, 1'b0);

    // hold 0 behaves as hold 1
    do_reset(); clear_log();
    wr(2'd1, {16'd0, 16'h1111});
    wr(2'd1, {16'd1, 16'h2222});
    wr(2'd1, {16'd0, 16'h3333});
    wr(2'd0, 32'h1); c_start = cyc;
    idle(6);
    check_val("t2_n_strobes", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      check_val("t2_gap0", strobe_cyc[1] - strobe_cyc[0], 1);
      check_val("t2_gap1", strobe_cyc[2] - strobe_cyc[1], 1);
    end
    check_val("t2_n_done", done_cyc.size(), 1);
    if (done_cyc.size() == 1) check_val("t2_done_at", done_cyc[0] - c_start, 4);

    // overflow and clear
    do_reset();
    for (int i = 0; i <= DEPTH; i++) wr(2'd1, {16'd1, 16'(i)});
    tick(1'b0, 1'b0, 2'd0, 32'h0);
    check_val("t3_count_full", last_rd[23:16], DEPTH);
    check_val("t3_err_set", last_rd[31], 1'b1);
    wr(2'd2, 32'h0);
    tick(1'b0, 1'b0, 2'd0, 32'h0);
    check_val("t3_count_clr", last_rd[23:16], 0);
    check_val("t3_err_clr", last_rd[31], 1'b0);

    // loop mode, then stop
    do_reset(); clear_log();
    wr(2'd1, {16'd2, 16'h0F0F});
    wr(2'd1, {16'd2, 16'hF0F0});
    wr(2'd0, 32'h5); c_start = cyc;
    idle(9);
    wr(2'd0, 32'h2);
    idle(3);
    exp_n = LOOP_EN ? 5 : 2;
    exp_d = LOOP_EN ? 0 : 1;
    check_val("t4_n_strobes", strobe_cyc.size(), exp_n);
    check_val("t4_n_done", done_cyc.size(), exp_d);
    for (int i = 0; i < strobe_cyc.size(); i++) begin
      check_val("t4_pat", strobe_pat[i], (i % 2 == 0) ? 16'h0F0F : 16'hF0F0);
      if (i > 0) check_val("t4_spacing", strobe_cyc[i] - strobe_cyc[i-1], 2);
    end
    check_val("t4_busy_after", busy, 1'b0);

    // pause inside a hold-4 step, resume
    do_reset(); clear_log();
    wr(2'd1, {16'd4, 16'h1234});
    wr(2'd1, {16'd1, 16'h4321});
    wr(2'd0, 32'h1); c_start = cyc;
    wr(2'd0, 32'h8);
    idle(10);
    wr(2'd0, 32'h10); c_res = cyc;
    idle(6);
    check_val("t5_n_strobes", strobe_cyc.size(), 2);
    if (strobe_cyc.size() == 2) begin
      check_val("t5_first_lat", strobe_cyc[0] - c_start, 1);
      check_val("t5_resume_lat", strobe_cyc[1] - c_res, 4);
    end
    check_val("t5_n_done", done_cyc.size(), 1);

    // reset during step 1 hold cycles
    do_reset(); clear_log();
    wr(2'd1, {16'd3, 16'hAAAA});
    wr(2'd1, {16'd3, 16'h5555});
    wr(2'd0, 32'h1);
    idle(5);
    tick(1'b1, 1'b0, 2'd0, 32'h0);
    tick(1'b0, 1'b0, 2'd0, 32'h0);
    check_val("t6_dout_wd", last_wd, 16'h0);
    check_val("t6_dout_we", last_we, 1'b0);
    check_val("t6_done", last_done, 1'b0);
    check_val("t6_busy", last_busy, 1'b0);
    check_val("t6_state", last_rd[1:0], 2'd0);
    check_val("t6_n_strobes", strobe_cyc.size(), 2);
    check_val("t6_n_done", done_cyc.size(), 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 1) tick(1'b1, 1'b0, 2'd0, 32'h0);
      else if (sel < 45) idle(1);
      else if (sel < 70) wr(2'd1, {16'($urandom_range(0, 4)), 16'($urandom)});
      else if (sel < 95) begin
        k = $urandom_range(0, 5);
        case (k)
          0: w = 32'h1;
          1: w = 32'h2;
          2: w = 32'h8;
          3: w = 32'h10;
          default: w = $urandom & 32'h1F;
        endcase
        w[2] = 1'($urandom_range(0, 1));
        wr(2'd0, w);
      end
      else if (sel < 98) wr(2'd2, 32'h0);
      else wr(2'd3, $urandom);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dout_sequencer.md
DOUT_SEQUENCER -- requirements
Module: dout_sequencer

Interface
REQ-001 The block SHALL have parameter N_OUTPUTS, default 16, meaning the width of the pattern driven to the digital output register (1..16).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of step-memory entries (power of two, 2..64).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 A  input  2  register select (0 CTRL, 1 STEP, 2 CLEAR, 3 reserved).
REQ-006 WD  input  32  bus write data.
REQ-007 WE  input  1  bus write enable; one write per asserted cycle.
REQ-008 RD  output  32  read data for A, combinational.
REQ-009 DOUT_WD  output  N_OUTPUTS  pattern to the digital output register.
REQ-010 DOUT_WE  output  1  write strobe to the digital output register.
REQ-011 busy  output  1  high in RUN or PAUSE.
REQ-012 done  output  1  one-cycle pulse at natural end of sequence.

Function
REQ-013 A STEP write SHALL append {hold=WD[31:16], pattern=WD[N_OUTPUTS-1:0]} at index count, then count+1; ignored, with sticky err set, when count==DEPTH or busy is high.
REQ-014 A CLEAR write SHALL set count=0 and clear err; ignored when busy is high.
REQ-015 CTRL write bits: 0 start, 1 stop, 2 loop (stored), 3 pause, 4 resume; multiple bits in one write resolve with priority stop > start > pause > resume.
REQ-016 FSM states SHALL be IDLE, RUN, PAUSE.
REQ-017 IDLE->RUN on start with count>0: idx=0, the step-0 strobe occurs in the next cycle; start with count==0 is ignored.
REQ-018 Each step SHALL occupy exactly max(hold,1) RUN cycles; DOUT_WE=1 with DOUT_WD=pattern[idx] in the first cycle only, DOUT_WE=0 otherwise.
REQ-019 After the last cycle of step count-1: if loop, idx wraps to 0 with no gap cycle; else go to IDLE and pulse done in the same cycle as the transition.
REQ-020 RUN->PAUSE on pause: the hold counter freezes and DOUT_WE=0; PAUSE->RUN on resume continues the remaining cycles of the same step without re-strobing.
REQ-021 Stop from RUN or PAUSE SHALL go to IDLE next cycle with no done pulse and no further strobe; the output register keeps its last value.
REQ-022 Start while busy, and pause/resume in the wrong state, SHALL be ignored.
REQ-023 RD: A=0 {err[31], count[23:16], idx[15:8], loop[4], state[1:0]}; A=1 pattern/hold of entry idx; A=2,3 zero; unused bits zero.
REQ-024 DOUT_WD SHALL hold its last value when DOUT_WE=0.

Reset
REQ-025 On rst: state=IDLE, count=0, idx=0, hold counter=0, loop=0, err=0, DOUT_WD=0, DOUT_WE=0, busy=0, done=0; step-memory contents need not be cleared.
REQ-026 rst mid-sequence SHALL abort with no strobe or done in the reset cycle or the following cycle.

Configuration
REQ-027 With macro DOUT_SEQ_LOOP_EN defined, loop mode SHALL behave per REQ-019.
REQ-028 Without DOUT_SEQ_LOOP_EN, CTRL bit 2 SHALL be ignored, RD loop bit SHALL read 0, and every sequence SHALL end with done.

Verification
REQ-029 Push {hold 3, 0x00A5} and {hold 1, 0x5A00}, then start -> DOUT_WE pulses 3 cycles apart with 0x00A5 then 0x5A00; done one cycle after the second strobe; busy low afterwards.
REQ-030 Push a step with hold 0 -> the step lasts 1 cycle, identical to hold 1.
REQ-031 Push DEPTH+1 steps -> count reads DEPTH and err=1; CLEAR -> count=0 and err=0.
REQ-032 Loop with 2 steps of hold 2 -> strobes every 2 cycles alternating patterns, no done; stop -> IDLE, no done pulse.
REQ-033 Pause after 1 cycle of hold 4, wait 10 cycles, resume -> next strobe exactly 3 RUN cycles after resume.
REQ-034 Assert rst during the HOLD cycles of step 1 -> all outputs zero and state IDLE next cycle, with no strobe.
